// File: rtl/pwm_rgb_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_rgb_mul_pkg
// Brief   : Shared constants and helpers for the pwm_rgb pipelined multiplier.
// Rev     : 1.0  initial release
// ============================================================================
package pwm_rgb_mul_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 4;

    typedef enum logic {
        MUL_UNSIGNED = 1'b0,
        MUL_SIGNED   = 1'b1
    } mul_mode_e;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    // Bounds are returned in 64 bits; callers keep the low 'width' bits.
    function automatic logic [63:0] sat_max(input int width, input bit is_signed);
        logic [63:0] ones;
        ones = (64'd1 << width) - 64'd1;
        return is_signed ? (ones >> 1) : ones;
    endfunction

    function automatic logic [63:0] sat_min(input int width, input bit is_signed);
        return is_signed ? ~((64'd1 << (width - 1)) - 64'd1) : 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_rgb_mul_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : pwm_rgb_mul_pipe_if
// Brief   : Operand/result valid-ready bundle for pwm_rgb_mul_pipe.
// Rev     : 1.0  initial release
// ============================================================================
interface pwm_rgb_mul_pipe_if #(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 23
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  sat_flag;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, sat_flag
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/pwm_rgb_mul_sat.sv
`default_nettype none
// ============================================================================
// Module  : pwm_rgb_mul_sat
// Brief   : Reduces the full product to DOUT_WIDTH; saturates when
//           PWM_RGB_MUL_SAT_EN is defined, otherwise truncates.
// Rev     : 1.0  initial release
// ============================================================================
module pwm_rgb_mul_sat
    import pwm_rgb_mul_pkg::*;
#(
    parameter int P_WIDTH     = 23,
    parameter int DOUT_WIDTH  = 23,
    parameter int SIGNED_MODE = 0
) (
    input  wire logic [P_WIDTH-1:0]    prod,
    output logic      [DOUT_WIDTH-1:0] res,
    output logic                       sat
);
`ifdef PWM_RGB_MUL_SAT_EN
    if (DOUT_WIDTH < P_WIDTH) begin : g_sat
        localparam bit                IS_SIGNED = (SIGNED_MODE == int'(MUL_SIGNED));
        localparam logic [63:0]       C_MAX     = sat_max(DOUT_WIDTH, IS_SIGNED);
        localparam logic [63:0]       C_MIN     = sat_min(DOUT_WIDTH, IS_SIGNED);
        logic [P_WIDTH-DOUT_WIDTH-1:0] upper;
        logic                          ovf;

        assign upper = prod[P_WIDTH-1:DOUT_WIDTH];

        // Signed fit: every discarded bit must replicate the kept MSB.
        always_comb begin
            ovf = 1'b0;
            if (IS_SIGNED) begin
                ovf = (upper != {(P_WIDTH-DOUT_WIDTH){prod[DOUT_WIDTH-1]}});
            end else begin
                ovf = |upper;
            end
            res = prod[DOUT_WIDTH-1:0];
            if (ovf) begin
                res = (IS_SIGNED && prod[P_WIDTH-1]) ? C_MIN[DOUT_WIDTH-1:0]
                                                     : C_MAX[DOUT_WIDTH-1:0];
            end
            sat = ovf;
        end
    end else begin : g_full
        localparam int unused_mode = SIGNED_MODE;
        assign res = prod[DOUT_WIDTH-1:0];
        assign sat = 1'b0;
    end
`else
    localparam int unused_mode = SIGNED_MODE;
    logic unused_prod;
    assign unused_prod = ^prod;
    assign res = prod[DOUT_WIDTH-1:0];
    assign sat = 1'b0;
`endif
endmodule
`default_nettype wire

// File: rtl/pwm_rgb_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module  : pwm_rgb_mul_pipe
// Brief   : Pipelined brightness x scale multiplier with valid/ready stall.
//           Optional saturation: define PWM_RGB_MUL_SAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module pwm_rgb_mul_pipe
    import pwm_rgb_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 8,
    parameter int DIN1_WIDTH  = 15,
    parameter int DOUT_WIDTH  = 23,
    parameter int NUM_STAGE   = 2,
    parameter int SIGNED_MODE = 0
) (
    input  wire logic          ap_clk,
    input  wire logic          ap_rst_n,
    pwm_rgb_mul_pipe_if.slave  bus
);
    localparam int P         = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int STAGES    = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                               (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;
    localparam bit IS_SIGNED = (SIGNED_MODE == int'(MUL_SIGNED));

    logic                  adv;
    logic [STAGES-1:0]     vld_q, vld_d;
    logic [DIN0_WIDTH-1:0] a_q, a_d;
    logic [DIN1_WIDTH-1:0] b_q, b_d;
    logic [P-1:0]          a_ext, b_ext, prod;
    logic [DOUT_WIDTH-1:0] red;
    logic                  red_sat;

    // Single global enable: the whole pipe moves unless the output is blocked.
    assign adv           = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[STAGES-1];

    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        if (adv) begin
            vld_d    = vld_q << 1;
            vld_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                a_d = bus.din0;
                b_d = bus.din1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    // Operands widened to P so the low P bits of the product are exact.
    always_comb begin
        if (IS_SIGNED) begin
            a_ext = {{(P-DIN0_WIDTH){a_q[DIN0_WIDTH-1]}}, a_q};
            b_ext = {{(P-DIN1_WIDTH){b_q[DIN1_WIDTH-1]}}, b_q};
        end else begin
            a_ext = P'(a_q);
            b_ext = P'(b_q);
        end
        prod = a_ext * b_ext;
    end

    pwm_rgb_mul_sat #(
        .P_WIDTH    (P),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SIGNED_MODE(SIGNED_MODE)
    ) u_sat (
        .prod(prod),
        .res (red),
        .sat (red_sat)
    );

    if (STAGES == 1) begin : g_one
        assign bus.dout     = red;
        assign bus.sat_flag = red_sat;
    end else begin : g_multi
        logic [STAGES-1:1][DOUT_WIDTH-1:0] res_q, res_d;
        logic [STAGES-1:1]                 sat_q, sat_d;

        always_comb begin
            res_d = res_q;
            sat_d = sat_q;
            if (adv) begin
                res_d[1] = red;
                sat_d[1] = red_sat;
                for (int i = 2; i < STAGES; i++) begin
                    res_d[i] = res_q[i-1];
                    sat_d[i] = sat_q[i-1];
                end
            end
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                res_q <= '0;
                sat_q <= '0;
            end else begin
                res_q <= res_d;
                sat_q <= sat_d;
            end
        end

        assign bus.dout     = res_q[STAGES-1];
        assign bus.sat_flag = sat_q[STAGES-1];
    end
endmodule
`default_nettype wire

// File: tb/tb_pwm_rgb_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_rgb_mul_pipe
// Brief   : Directed self-checking bench for pwm_rgb_mul_pipe over several
//           configurations; expectations follow PWM_RGB_MUL_SAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pwm_rgb_mul_pipe;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst_n4 = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   tx;
    int   rx;
    int   bp_exp [4];

`ifdef PWM_RGB_MUL_SAT_EN
    localparam logic [7:0] EXP_U8      = 8'hFF;
    localparam logic       EXP_U8_SAT  = 1'b1;
    localparam logic [7:0] EXP_S8A     = 8'h80;
    localparam logic       EXP_S8A_SAT = 1'b1;
`else
    localparam logic [7:0] EXP_U8      = 8'h90;
    localparam logic       EXP_U8_SAT  = 1'b0;
    localparam logic [7:0] EXP_S8A     = 8'hD4;
    localparam logic       EXP_S8A_SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    pwm_rgb_mul_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(15), .DOUT_WIDTH(23)) m_def ();
    pwm_rgb_mul_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8),  .DOUT_WIDTH(16)) m_s16 ();
    pwm_rgb_mul_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8),  .DOUT_WIDTH(8))  m_u8 ();
    pwm_rgb_mul_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8),  .DOUT_WIDTH(8))  m_s8 ();
    pwm_rgb_mul_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8),  .DOUT_WIDTH(16)) m_p4 ();

    pwm_rgb_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(15), .DOUT_WIDTH(23), .NUM_STAGE(2), .SIGNED_MODE(0))
        u_def (.ap_clk(clk), .ap_rst_n(rst_n), .bus(m_def));
    pwm_rgb_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(2), .SIGNED_MODE(1))
        u_s16 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(m_s16));
    pwm_rgb_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(2), .SIGNED_MODE(0))
        u_u8 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(m_u8));
    pwm_rgb_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(1), .SIGNED_MODE(1))
        u_s8 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(m_s8));
    pwm_rgb_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(4), .SIGNED_MODE(0))
        u_p4 (.ap_clk(clk), .ap_rst_n(rst_n4), .bus(m_p4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bp_exp = '{1, 4, 9, 16};
        m_def.in_valid = 1'b0; m_def.din0 = '0; m_def.din1 = '0; m_def.out_ready = 1'b0;
        m_s16.in_valid = 1'b0; m_s16.din0 = '0; m_s16.din1 = '0; m_s16.out_ready = 1'b1;
        m_u8.in_valid  = 1'b0; m_u8.din0  = '0; m_u8.din1  = '0; m_u8.out_ready  = 1'b1;
        m_s8.in_valid  = 1'b0; m_s8.din0  = '0; m_s8.din1  = '0; m_s8.out_ready  = 1'b1;
        m_p4.in_valid  = 1'b0; m_p4.din0  = '0; m_p4.din1  = '0; m_p4.out_ready  = 1'b1;

        // Reset state, sampled while reset is still held.
        @(negedge clk);
        chk("rst_out_valid", 64'(m_def.out_valid), 64'd0);
        chk("rst_dout",      64'(m_def.dout),      64'd0);
        chk("rst_sat_flag",  64'(m_def.sat_flag),  64'd0);
        chk("rst_in_ready",  64'(m_def.in_ready),  64'd1);
        chk("rst_p4_valid",  64'(m_p4.out_valid),  64'd0);
        rst_n = 1'b1; rst_n4 = 1'b1;

        // Default config: 255 x 32767, latency 2.
        @(negedge clk);
        m_def.out_ready = 1'b1; m_def.in_valid = 1'b1;
        m_def.din0 = 8'd255; m_def.din1 = 15'd32767;
        @(negedge clk);
        m_def.in_valid = 1'b0;
        chk("def_valid_cyc1", 64'(m_def.out_valid), 64'd0);
        @(negedge clk);
        chk("def_valid_cyc2", 64'(m_def.out_valid), 64'd1);
        chk("def_dout",       64'(m_def.dout),      64'h7F7F01);
        chk("def_sat",        64'(m_def.sat_flag),  64'd0);

        // Back-pressure stream 1,4,9,16 with the consumer stalled on k=3..6.
        tx = 0; rx = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            m_def.out_ready = !(k >= 3 && k <= 6);
            m_def.in_valid  = (tx < 4);
            m_def.din0      = 8'(tx + 1);
            m_def.din1      = 15'(tx + 1);
            #1;
            if (m_def.out_valid) begin
                if (rx < 4) begin
                    chk("bp_dout", 64'(m_def.dout), 64'(bp_exp[rx]));
                    if (m_def.out_ready) rx++;
                end else begin
                    chk("bp_extra_valid", 64'(m_def.out_valid), 64'd0);
                end
            end
            if (k >= 3 && k <= 6) chk("bp_in_ready_stall", 64'(m_def.in_ready), 64'd0);
            if (m_def.in_valid && m_def.in_ready) tx++;
        end
        m_def.in_valid = 1'b0;
        chk("bp_rx_count", 64'(rx), 64'd4);
        chk("bp_tx_count", 64'(tx), 64'd4);

        // Signed 8x8->16 and unsigned 8x8->8 side by side.
        @(negedge clk);
        m_s16.in_valid = 1'b1; m_s16.din0 = 8'h80; m_s16.din1 = 8'h7F;
        m_u8.in_valid  = 1'b1; m_u8.din0  = 8'd20; m_u8.din1  = 8'd20;
        @(negedge clk);
        m_s16.in_valid = 1'b0; m_u8.in_valid = 1'b0;
        chk("s16_valid_cyc1", 64'(m_s16.out_valid), 64'd0);
        @(negedge clk);
        chk("s16_valid", 64'(m_s16.out_valid), 64'd1);
        chk("s16_dout",  64'(m_s16.dout),      64'hC080);
        chk("u8_valid",  64'(m_u8.out_valid),  64'd1);
        chk("u8_dout",   64'(m_u8.dout),       64'(EXP_U8));
        chk("u8_sat",    64'(m_u8.sat_flag),   64'(EXP_U8_SAT));

        // Signed 8x8->8 with a single stage: -100 x 3 then 5 x -5.
        @(negedge clk);
        m_s8.in_valid = 1'b1; m_s8.din0 = 8'h9C; m_s8.din1 = 8'h03;
        @(negedge clk);
        chk("s8a_valid", 64'(m_s8.out_valid), 64'd1);
        chk("s8a_dout",  64'(m_s8.dout),      64'(EXP_S8A));
        chk("s8a_sat",   64'(m_s8.sat_flag),  64'(EXP_S8A_SAT));
        m_s8.din0 = 8'h05; m_s8.din1 = 8'hFB;
        @(negedge clk);
        m_s8.in_valid = 1'b0;
        chk("s8b_valid", 64'(m_s8.out_valid), 64'd1);
        chk("s8b_dout",  64'(m_s8.dout),      64'hE7);
        chk("s8b_sat",   64'(m_s8.sat_flag),  64'd0);
        @(negedge clk);
        chk("s8_drained", 64'(m_s8.out_valid), 64'd0);

        // Four-stage pipe: reset with three beats in flight.
        @(negedge clk);
        m_p4.in_valid = 1'b1; m_p4.din0 = 8'd1; m_p4.din1 = 8'd1;
        @(negedge clk);
        m_p4.din0 = 8'd2; m_p4.din1 = 8'd2;
        @(negedge clk);
        m_p4.din0 = 8'd3; m_p4.din1 = 8'd3;
        @(negedge clk);
        m_p4.in_valid = 1'b0;
        chk("p4_valid_cyc3", 64'(m_p4.out_valid), 64'd0);
        @(negedge clk);
        chk("p4_valid_cyc4", 64'(m_p4.out_valid), 64'd1);
        chk("p4_dout_first", 64'(m_p4.dout),      64'd1);
        #1 rst_n4 = 1'b0;
        #1;
        chk("p4_rst_valid",    64'(m_p4.out_valid), 64'd0);
        chk("p4_rst_dout",     64'(m_p4.dout),      64'd0);
        chk("p4_rst_sat",      64'(m_p4.sat_flag),  64'd0);
        chk("p4_rst_in_ready", 64'(m_p4.in_ready),  64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("p4_no_stale", 64'(m_p4.out_valid), 64'd0);
        end
        @(negedge clk);
        m_p4.in_valid = 1'b1; m_p4.din0 = 8'd7; m_p4.din1 = 8'd9;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            m_p4.in_valid = 1'b0;
            chk("p4_new_latency", 64'(m_p4.out_valid), 64'd0);
        end
        @(negedge clk);
        chk("p4_new_valid", 64'(m_p4.out_valid), 64'd1);
        chk("p4_new_dout",  64'(m_p4.dout),      64'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_rgb_mul_pipe.md
Name: pwm_rgb_mul_pipe

Overview:
- Parametrised, pipelined multiplier for the pwm_rgb datapath. It replaces the fixed-width combinational 8x15 multiply.
- Computes duty = brightness * period-scale with selectable signedness and a configurable pipeline depth.
- Valid/ready handshake with back-pressure, so it slots between the colour-register stage and the PWM compare counter.
- Product is truncated to the output width or, optionally, saturated.

Parameters:
- DIN0_WIDTH, 8, width of operand a (brightness).
- DIN1_WIDTH, 15, width of operand b (scale).
- DOUT_WIDTH, 23, result width; legal range 1..DIN0_WIDTH+DIN1_WIDTH.
- NUM_STAGE, 2, pipeline register stages; legal range 1..4. Latency equals NUM_STAGE.
- SIGNED_MODE, 0, 0 = unsigned x unsigned, 1 = two's-complement signed x signed.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- din0  in  DIN0_WIDTH  operand a.
- din1  in  DIN1_WIDTH  operand b.
- out_valid  out  1  dout holds a result.
- out_ready  in  1  consumer accepts dout this cycle.
- dout  out  DOUT_WIDTH  product, truncated or saturated.
- sat_flag  out  1  result was clipped; constant 0 when the feature is compiled out.

Behaviour:
- One clock: ap_clk. Reset ap_rst_n is asynchronous, active-low; assertion clears all pipeline state immediately.
- Reset values: every stage valid bit 0, every stage data register 0, out_valid 0, dout 0, sat_flag 0. in_ready is 1 during and after reset, because the pipeline is empty.
- Full product width P = DIN0_WIDTH + DIN1_WIDTH.
  - SIGNED_MODE=0: both operands zero-extended to P.
  - SIGNED_MODE=1: both operands sign-extended to P.
  - The product is exact in P bits in both modes.
- Pipeline advance: adv = out_ready | ~out_valid. One global enable; all stages shift together when adv=1 and hold when adv=0.
- in_ready = adv (combinational).
- Accept condition: a beat is accepted when in_valid & in_ready. Stage 1 then captures the operands and sets valid=1. If adv=1 and in_valid=0, stage 1 valid is cleared (bubble).
- Stage usage:
  - Stage 1 registers the operands.
  - The multiply sits between stage 1 and stage 2, or feeds the output directly when NUM_STAGE=1.
  - Remaining stages are delay registers; the output reduction (truncate/saturate) is applied before the last stage.
- Latency: an accepted beat appears on dout/out_valid exactly NUM_STAGE cycles later if never stalled. Every stall cycle adds one.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 freezes all stages. dout stays stable and in_ready=0. Nothing is dropped or duplicated.
- Simultaneous events: the output is consumed and a new input accepted in the same cycle → both happen; the pipeline stays full.
- Bubbles: while the pipeline is not full, bubbles collapse only at the output stage (simple global stall). Full bubble compression is not required.
- Truncation (no SAT): dout = product[DOUT_WIDTH-1:0]. The upper bits are discarded (wrap-around).
- Reset mid-operation: all in-flight beats are discarded; out_valid drops asynchronously. No partial result appears after release.
- Data registers of invalid stages are don't-care except at reset. dout is only meaningful when out_valid=1.

Optional Feature:
- Macro: PWM_RGB_MUL_SAT_EN.
- Defined, unsigned mode: if any product bit above DOUT_WIDTH-1 is set, dout = all-ones and sat_flag=1.
- Defined, signed mode: if the product does not fit in DOUT_WIDTH signed, dout = the most positive or most negative value according to the product sign, and sat_flag=1.
- sat_flag is pipelined alongside dout and qualified by out_valid.
- Not defined: plain truncation; sat_flag tied 0. No saturation logic is synthesised.
- When DOUT_WIDTH == P, saturation never triggers in either build.

Decomposition:
- Package pwm_rgb_mul_pkg holds:
  - localparams for the legal NUM_STAGE range;
  - a function computing P;
  - enum/constants MUL_UNSIGNED=0 and MUL_SIGNED=1;
  - the saturation bound helper functions (max/min for a given width and signedness).
- One sub-module: pwm_rgb_mul_sat, the combinational reduction from P bits to DOUT_WIDTH plus the flag. Instantiated before the last stage.

Test Plan:
- Unsigned, defaults: din0=255, din1=32767, in_valid=1, out_ready=1 → after 2 cycles out_valid=1, dout=8355585 (0x7F7F01).
- Back-pressure: stream 1x1, 2x2, 3x3, 4x4 with out_ready held 0 for cycles 3-6 → in_ready=0 during the stall; outputs 1,4,9,16 in order, none lost or repeated, dout stable while stalled.
- SIGNED_MODE=1, DIN0_WIDTH=8, DIN1_WIDTH=8, DOUT_WIDTH=16: din0=-128 (0x80), din1=127 (0x7F) → dout=-16256 (0xC080).
- DOUT_WIDTH=8, unsigned, 20x20=400:
  - Without PWM_RGB_MUL_SAT_EN → dout=144 (0x90), sat_flag=0.
  - With the macro → dout=255, sat_flag=1.
- Signed, DOUT_WIDTH=8, with the macro: -100 x 3 → dout=-128 (0x80), sat_flag=1; 5 x -5 → dout=-25, sat_flag=0.
- Reset mid-stream: NUM_STAGE=4; assert ap_rst_n=0 asynchronously with 3 beats in flight → out_valid, dout, sat_flag go 0 before the next edge. After release, no stale beat ever appears; the first new beat emerges after 4 cycles.
